// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin sharing of one single-port BRAM (1-cycle read latency)
// among NUM_REQ requesters, one access per cycle, with read-valid routed back to the
// requester that issued the read.
// Optional feature: define BRAM_ARB_LOCK_EN to add the req_lock port and an
// IDLE/LOCKED FSM that reserves the BRAM for one owner (atomic read-modify-write).
module bram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]             req_lock,
`endif
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_w_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             r_valid,
  output logic [DATA_WIDTH-1:0]          r_data,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_w_data,
  output logic                           mem_we,
  input  logic [DATA_WIDTH-1:0]          mem_r_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   winner;
  logic               found;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] r_valid_q;

  // Index of the next requester after v, wrapping the last one back to 0.
  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
    if (int'(v) == NUM_REQ - 1) begin
      return '0;
    end else begin
      return v + 1'b1;
    end
  endfunction

`ifdef BRAM_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t      state, state_next;
  logic [IDX_W-1:0] owner, owner_next;
  logic             owner_drop;

  // Lock state register: reset returns to IDLE with owner 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  // Next lock state: lock on a grant with req_lock, release on an unlocked owner access or owner leaving.
  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (found && req_lock[winner]) begin
          state_next = LOCKED;
          owner_next = winner;
        end
      end
      LOCKED: begin
        if (!req[owner] || !req_lock[owner]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lock outputs: while LOCKED only the owner may compete; flag the owner giving up the lock.
  always_comb begin
    eligible   = req;
    owner_drop = 1'b0;
    if (state == LOCKED) begin
      eligible        = '0;
      eligible[owner] = req[owner];
      owner_drop      = !req[owner];
    end
  end
`else
  // Without locking every requesting port competes.
  always_comb begin
    eligible = req;
  end
`endif

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  // Steer the winner onto the bus; idle or reset cycles drive zeros so nothing is written.
  always_comb begin
    gnt        = '0;
    mem_addr   = '0;
    mem_w_data = '0;
    mem_we     = 1'b0;
    if (found && !rst) begin
      gnt[winner] = 1'b1;
      mem_addr    = req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
      mem_w_data  = req_w_data[winner*DATA_WIDTH +: DATA_WIDTH];
      mem_we      = req_we[winner];
    end
  end

  // Pointer moves just past each winner; the owner leaving a lock hands priority to the next port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
`ifdef BRAM_ARB_LOCK_EN
    end else if (owner_drop) begin
      rr_ptr <= inc_wrap(owner);
`endif
    end else if (found) begin
      rr_ptr <= inc_wrap(winner);
    end
  end

  // Reads granted this cycle come back next cycle, aligned with the BRAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q <= '0;
    end else begin
      r_valid_q <= gnt & ~req_we;
    end
  end

  // A reset arriving while a read is in flight suppresses its valid.
  always_comb begin
    r_valid = r_valid_q & {NUM_REQ{~rst}};
    r_data  = mem_r_data;
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed bench for bram_arbiter with two-port and three-port
// instances, each attached to a small synchronous BRAM model.
module tb_bram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  // Two-requester instance
  logic [1:0]  req, req_we, req_lock;
  logic [19:0] req_addr;
  logic [63:0] req_w_data;
  logic [1:0]  gnt, r_valid;
  logic [31:0] r_data, mem_w_data, mem_r_data;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem [0:1023];

  bram_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we),
`ifdef BRAM_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_addr(req_addr), .req_w_data(req_w_data), .gnt(gnt), .r_valid(r_valid),
    .r_data(r_data), .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_we(mem_we),
    .mem_r_data(mem_r_data)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_w_data;
    mem_r_data <= mem[mem_addr];
  end

  // Three-requester instance
  logic [2:0]  req3, req_we3, req_lock3;
  logic [29:0] req_addr3;
  logic [95:0] req_w_data3;
  logic [2:0]  gnt3, r_valid3;
  logic [31:0] r_data3, mem_w_data3, mem_r_data3;
  logic [9:0]  mem_addr3;
  logic        mem_we3;
  logic [31:0] mem3 [0:1023];

  bram_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(10), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_we(req_we3),
`ifdef BRAM_ARB_LOCK_EN
    .req_lock(req_lock3),
`endif
    .req_addr(req_addr3), .req_w_data(req_w_data3), .gnt(gnt3), .r_valid(r_valid3),
    .r_data(r_data3), .mem_addr(mem_addr3), .mem_w_data(mem_w_data3), .mem_we(mem_we3),
    .mem_r_data(mem_r_data3)
  );

  always @(posedge clk) begin
    if (mem_we3) mem3[mem_addr3] <= mem_w_data3;
    mem_r_data3 <= mem3[mem_addr3];
  end

  // Hold reset for two edges; returns at a negedge with rst released and all requests idle.
  task apply_reset();
    rst = 1'b1;
    req = '0; req_we = '0; req_lock = '0;
    req3 = '0; req_we3 = '0; req_lock3 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task test_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b01; req_we = 2'b01; req_addr = {10'd0, 10'd5}; req_w_data = {32'd0, 32'hDEAD};
    @(negedge clk);
    #1;
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("[TB] FAIL reset_gnt got %b want 00", gnt); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("[TB] FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (r_valid !== 2'b00) begin n_err++; $display("[TB] FAIL reset_r_valid got %b want 00", r_valid); end
    n_cmp++; if (mem_addr !== 10'd0) begin n_err++; $display("[TB] FAIL reset_mem_addr got %0d want 0", mem_addr); end
    req = '0; req_we = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task test_single_read();
    apply_reset();
    req = 2'b01; req_we = 2'b00; req_addr = {10'd0, 10'd5};
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("[TB] FAIL t1_gnt got %b want 01", gnt); end
    n_cmp++; if (mem_addr !== 10'd5) begin n_err++; $display("[TB] FAIL t1_mem_addr got %0d want 5", mem_addr); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("[TB] FAIL t1_mem_we got %b want 0", mem_we); end
    @(negedge clk);
    req = 2'b00;
    #1;
    n_cmp++; if (r_valid !== 2'b01) begin n_err++; $display("[TB] FAIL t1_r_valid got %b want 01", r_valid); end
    n_cmp++; if (r_data !== 32'hAB) begin n_err++; $display("[TB] FAIL t1_r_data got %h want 000000ab", r_data); end
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("[TB] FAIL t1_gnt_idle got %b want 00", gnt); end
    @(negedge clk);
    #1;
    n_cmp++; if (r_valid !== 2'b00) begin n_err++; $display("[TB] FAIL t1_r_valid_clear got %b want 00", r_valid); end
  endtask

  task test_round_robin();
    logic [1:0]  exp_g [5];
    logic [1:0]  exp_v [5];
    logic [31:0] exp_d [5];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    exp_v = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    exp_d = '{32'h0, 32'h111, 32'h222, 32'h111, 32'h222};
    apply_reset();
    req_addr = {10'd11, 10'd10}; req_we = 2'b00;
    for (int c = 0; c < 5; c++) begin
      req = (c < 4) ? 2'b11 : 2'b00;
      #1;
      n_cmp++; if (gnt !== exp_g[c]) begin n_err++; $display("[TB] FAIL t2_gnt[%0d] got %b want %b", c, gnt, exp_g[c]); end
      n_cmp++; if (r_valid !== exp_v[c]) begin n_err++; $display("[TB] FAIL t2_r_valid[%0d] got %b want %b", c, r_valid, exp_v[c]); end
      if (c > 0) begin
        n_cmp++; if (r_data !== exp_d[c]) begin n_err++; $display("[TB] FAIL t2_r_data[%0d] got %h want %h", c, r_data, exp_d[c]); end
      end
      @(negedge clk);
    end
  endtask

  task test_write_then_read();
    int we_count;
    we_count = 0;
    apply_reset();
    req = 2'b10; req_we = 2'b10; req_addr = {10'd7, 10'd0}; req_w_data = {32'h1234, 32'h0};
    #1;
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("[TB] FAIL t3_wr_gnt got %b want 10", gnt); end
    n_cmp++; if (mem_w_data !== 32'h1234) begin n_err++; $display("[TB] FAIL t3_wr_data got %h want 00001234", mem_w_data); end
    if (mem_we === 1'b1) we_count++;
    @(negedge clk);
    req = 2'b01; req_we = 2'b00; req_addr = {10'd0, 10'd7};
    #1;
    n_cmp++; if (r_valid !== 2'b00) begin n_err++; $display("[TB] FAIL t3_wr_no_valid got %b want 00", r_valid); end
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("[TB] FAIL t3_rd_gnt got %b want 01", gnt); end
    if (mem_we === 1'b1) we_count++;
    @(negedge clk);
    req = 2'b00;
    #1;
    if (mem_we === 1'b1) we_count++;
    n_cmp++; if (r_valid !== 2'b01) begin n_err++; $display("[TB] FAIL t3_r_valid got %b want 01", r_valid); end
    n_cmp++; if (r_data !== 32'h1234) begin n_err++; $display("[TB] FAIL t3_r_data got %h want 00001234", r_data); end
    n_cmp++; if (we_count !== 1) begin n_err++; $display("[TB] FAIL t3_we_count got %0d want 1", we_count); end
  endtask

  task test_wrap_three();
    logic [2:0] exp_g [4];
    exp_g = '{3'b100, 3'b001, 3'b010, 3'b100};
    apply_reset();
    req_addr3 = {10'd3, 10'd2, 10'd1};
    for (int c = 0; c < 4; c++) begin
      req3 = (c == 0) ? 3'b100 : 3'b111;
      #1;
      n_cmp++; if (gnt3 !== exp_g[c]) begin n_err++; $display("[TB] FAIL t4_gnt[%0d] got %b want %b", c, gnt3, exp_g[c]); end
      @(negedge clk);
    end
    req3 = 3'b000;
  endtask

  task test_reset_mid_read();
    int we_count;
    we_count = 0;
    apply_reset();
    req = 2'b01; req_we = 2'b00; req_addr = {10'd10, 10'd5};
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("[TB] FAIL t5_gnt got %b want 01", gnt); end
    if (mem_we === 1'b1) we_count++;
    @(negedge clk);
    rst = 1'b1; req = 2'b10; req_we = 2'b10; req_w_data = {32'hBAD, 32'h0};
    #1;
    n_cmp++; if (r_valid !== 2'b00) begin n_err++; $display("[TB] FAIL t5_r_valid_rst got %b want 00", r_valid); end
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("[TB] FAIL t5_gnt_rst got %b want 00", gnt); end
    if (mem_we === 1'b1) we_count++;
    @(negedge clk);
    rst = 1'b0; req = 2'b11; req_we = 2'b00;
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("[TB] FAIL t5_ptr_reset got %b want 01", gnt); end
    n_cmp++; if (r_valid !== 2'b00) begin n_err++; $display("[TB] FAIL t5_r_valid_after got %b want 00", r_valid); end
    if (mem_we === 1'b1) we_count++;
    n_cmp++; if (we_count !== 0) begin n_err++; $display("[TB] FAIL t5_we_count got %0d want 0", we_count); end
    @(negedge clk);
    req = 2'b00;
  endtask

  task test_idle_and_back_to_back();
    apply_reset();
    req = 2'b00; req_we = 2'b11; req_addr = {10'd9, 10'd8}; req_w_data = {32'h55, 32'h66};
    #1;
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("[TB] FAIL idle_gnt got %b want 00", gnt); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("[TB] FAIL idle_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 10'd0) begin n_err++; $display("[TB] FAIL idle_mem_addr got %0d want 0", mem_addr); end
    n_cmp++; if (mem_w_data !== 32'd0) begin n_err++; $display("[TB] FAIL idle_mem_w_data got %h want 0", mem_w_data); end
    @(negedge clk);
    req = 2'b01; req_we = 2'b01; req_addr = {10'd0, 10'd20}; req_w_data = {32'h0, 32'hA1};
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("[TB] FAIL b2b_gnt0 got %b want 01", gnt); end
    @(negedge clk);
    req_addr = {10'd0, 10'd21}; req_w_data = {32'h0, 32'hA2};
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("[TB] FAIL b2b_gnt1 got %b want 01", gnt); end
    n_cmp++; if (mem_addr !== 10'd21) begin n_err++; $display("[TB] FAIL b2b_addr got %0d want 21", mem_addr); end
    n_cmp++; if (r_valid !== 2'b00) begin n_err++; $display("[TB] FAIL b2b_write_valid got %b want 00", r_valid); end
    @(negedge clk);
    req = 2'b00; req_we = 2'b00;
  endtask

`ifdef BRAM_ARB_LOCK_EN
  task test_lock();
    logic [1:0] exp_g [4];
    logic [1:0] lock_v [4];
    exp_g  = '{2'b01, 2'b01, 2'b01, 2'b10};
    lock_v = '{2'b01, 2'b01, 2'b00, 2'b00};
    apply_reset();
    req_we = 2'b00; req_addr = {10'd11, 10'd10};
    for (int c = 0; c < 4; c++) begin
      req = 2'b11; req_lock = lock_v[c];
      #1;
      n_cmp++; if (gnt !== exp_g[c]) begin n_err++; $display("[TB] FAIL t6_lock_gnt[%0d] got %b want %b", c, gnt, exp_g[c]); end
      @(negedge clk);
    end
    apply_reset();
    req = 2'b11; req_lock = 2'b01;
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("[TB] FAIL t6_take_gnt got %b want 01", gnt); end
    @(negedge clk);
    req = 2'b10; req_lock = 2'b00;
    #1;
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("[TB] FAIL t6_drop_gnt got %b want 00", gnt); end
    @(negedge clk);
    #1;
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("[TB] FAIL t6_after_drop_gnt got %b want 10", gnt); end
    @(negedge clk);
    req = 2'b00;
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_w_data = '0;
    req3 = '0; req_we3 = '0; req_lock3 = '0; req_addr3 = '0; req_w_data3 = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 32'd0;
      mem3[i] = 32'd0;
    end
    mem[5]  = 32'hAB;
    mem[10] = 32'h111;
    mem[11] = 32'h222;

    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_wrap_three();
    test_reset_mid_read();
    test_idle_and_back_to_back();
`ifdef BRAM_ARB_LOCK_EN
    test_lock();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
